centroid_updater: RTL and testbench

Downstream consumer of the cluster-assignment stage. It accumulates per-cluster coordinate sums and point counts over an epoch of labelled points. On `epoch_done` it computes each new centroid as the mean (sum / count) with a shared sequential divider, emits one update per cluster, then clears for the next epoch. Its outputs feed the centroid registers of the assignment stage.

---
 rtl/kmeans_pkg.sv | 23 ++
 rtl/seq_divider.sv | 76 +++++++
 rtl/centroid_updater.sv | 196 +++++++++++++++++++
 tb/tb_centroid_updater.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// kmeans_pkg: definitions shared by the k-means datapath blocks.
//   K        - number of clusters (IDs are 2 bits, legal 0..K-1)
//   COORD_W  - coordinate width, unsigned Q8.8
//   CNT_W    - per-cluster point counter width
//   SUM_W    - coordinate accumulator width (>= COORD_W + CNT_W)
//   cluster_id_t - cluster ID type
//   ST_*     - centroid_updater FSM state encoding
package kmeans_pkg;

    localparam int K       = 3;
    localparam int COORD_W = 16;
    localparam int CNT_W   = 16;
    localparam int SUM_W   = 32;

    typedef logic [1:0] cluster_id_t;

    localparam logic [2:0] ST_ACCUM = 3'd0;
    localparam logic [2:0] ST_DIV_X = 3'd1;
    localparam logic [2:0] ST_DIV_Y = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - sampled high: load dividend/divisor and begin
//   dividend  - SUM_W-bit numerator
//   divisor   - CNT_W-bit denominator (never zero when started)
//   done      - one-cycle pulse, SUM_W cycles after start is sampled
//   quotient  - floor(dividend / divisor), valid while done is high and
//               held until the next start
module seq_divider #(
    parameter int SUM_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int LW = $clog2(SUM_W + 1);

    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] dvs;
    logic [SUM_W-1:0] quo;
    logic [LW-1:0]    left;
    logic             run;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The remainder stays
    // below the divisor, so CNT_W bits hold it between steps.
    function automatic logic [CNT_W+SUM_W-1:0] div_step(
        input logic [CNT_W-1:0] r,
        input logic [SUM_W-1:0] q,
        input logic [CNT_W-1:0] d
    );
        logic [CNT_W:0] shifted;
        logic           fits;
        shifted = {r, q[SUM_W-1]};
        fits    = (shifted >= {1'b0, d});
        if (fits)
            shifted = shifted - {1'b0, d};
        return {shifted[CNT_W-1:0], q[SUM_W-2:0], fits};
    endfunction

    // The first step is taken on the start edge itself so that the final
    // step lands exactly SUM_W cycles after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            left <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            {rem, quo} <= div_step('0, dividend, divisor);
            dvs        <= divisor;
            left       <= LW'(SUM_W - 1);
            run        <= 1'b1;
            done       <= 1'b0;
        end else if (run) begin
            {rem, quo} <= div_step(rem, quo, dvs);
            left       <= left - 1'b1;
            run        <= (left != LW'(1));
            done       <= (left == LW'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/centroid_updater.sv
// centroid_updater: accumulates per-cluster coordinate sums and counts over
// an epoch, then on epoch_done emits each cluster's mean (sum / count)
// using one shared sequential divider, and clears for the next epoch.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   in_valid        - labelled point present this cycle
//   in_cluster      - cluster ID of the point (IDs >= K ignored)
//   in_x, in_y      - point coordinates (unsigned Q8.8)
//   epoch_done      - pulse ending accumulation
//   busy            - update sequence in progress
//   upd_valid       - one-cycle strobe per cluster
//   upd_id          - cluster being updated
//   upd_x, upd_y    - new centroid (0 when the cluster was empty)
//   upd_empty       - cluster had no points this epoch
//   ovf             - a point was dropped on a saturated counter (per epoch)
//   all_done        - pulse in the cycle after the last update
module centroid_updater #(
    parameter int K       = kmeans_pkg::K,
    parameter int COORD_W = kmeans_pkg::COORD_W,
    parameter int CNT_W   = kmeans_pkg::CNT_W,
    parameter int SUM_W   = kmeans_pkg::SUM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [1:0]         in_cluster,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic               epoch_done,
    output logic               busy,
    output logic               upd_valid,
    output logic [1:0]         upd_id,
    output logic [COORD_W-1:0] upd_x,
    output logic [COORD_W-1:0] upd_y,
    output logic               upd_empty,
    output logic               ovf,
    output logic               all_done
);

    import kmeans_pkg::*;

    localparam logic [2:0] K_LIM  = 3'(K);
    localparam logic [1:0] K_LAST = 2'(K - 1);

    logic [2:0]         state;
    cluster_id_t        k;
    logic [SUM_W-1:0]   sum_x [K];
    logic [SUM_W-1:0]   sum_y [K];
    logic [CNT_W-1:0]   cnt   [K];
    logic               ovf_r;
    logic               div_go;
    logic               div_done;
    logic [SUM_W-1:0]   div_quot;
    logic [SUM_W-1:0]   div_dividend;
    logic [COORD_W-1:0] upd_x_r;
    logic [COORD_W-1:0] upd_y_r;
    logic               upd_empty_r;

    logic               legal_pt;
    cluster_id_t        cid;
    logic               accept_pt;
    logic               dropped_pt;
    logic               nonempty0;
    cluster_id_t        k_next;

    function automatic logic cnt_full(input logic [CNT_W-1:0] c);
        return &c;
    endfunction

    // The mean never exceeds the largest coordinate, so the upper quotient
    // bits are always zero; clamp rather than wrap if that ever breaks.
    function automatic logic [COORD_W-1:0] quot_to_coord(input logic [SUM_W-1:0] q);
        if (|q[SUM_W-1:COORD_W])
            return '1;
        return q[COORD_W-1:0];
    endfunction

    // Accumulate stage: decode the incoming point
    assign legal_pt   = in_valid && ({1'b0, in_cluster} < K_LIM);
    assign cid        = legal_pt ? in_cluster : '0;
    assign accept_pt  = (state == ST_ACCUM) && legal_pt && !cnt_full(cnt[cid]);
    assign dropped_pt = (state == ST_ACCUM) && legal_pt && cnt_full(cnt[cid]);
    // A point arriving with epoch_done counts toward cluster 0's emptiness.
    assign nonempty0  = (cnt[0] != '0) || (accept_pt && (cid == 2'd0));
    assign k_next     = (k == K_LAST) ? k : k + 2'd1;

    // Divide stage: one divider shared across both axes and all clusters
    assign div_dividend = (state == ST_DIV_Y) ? sum_y[k] : sum_x[k];

    seq_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_go),
        .dividend (div_dividend),
        .divisor  (cnt[k]),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ACCUM;
            k           <= '0;
            div_go      <= 1'b0;
            ovf_r       <= 1'b0;
            upd_x_r     <= '0;
            upd_y_r     <= '0;
            upd_empty_r <= 1'b0;
            for (int i = 0; i < K; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            // div_go is high only in the first cycle of each DIV state.
            div_go <= 1'b0;
            case (state)
                ST_ACCUM: begin
                    if (accept_pt) begin
                        sum_x[cid] <= sum_x[cid] + SUM_W'(in_x);
                        sum_y[cid] <= sum_y[cid] + SUM_W'(in_y);
                        cnt[cid]   <= cnt[cid] + 1'b1;
                    end
                    if (dropped_pt)
                        ovf_r <= 1'b1;
                    if (epoch_done) begin
                        k <= '0;
                        if (nonempty0) begin
                            state  <= ST_DIV_X;
                            div_go <= 1'b1;
                        end else begin
                            state       <= ST_EMIT;
                            upd_empty_r <= 1'b1;
                            upd_x_r     <= '0;
                            upd_y_r     <= '0;
                        end
                    end
                end
                ST_DIV_X: begin
                    if (div_done) begin
                        upd_x_r <= quot_to_coord(div_quot);
                        state   <= ST_DIV_Y;
                        div_go  <= 1'b1;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done) begin
                        upd_y_r     <= quot_to_coord(div_quot);
                        upd_empty_r <= 1'b0;
                        state       <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (k == K_LAST) begin
                        state <= ST_CLEAR;
                    end else begin
                        k <= k_next;
                        if (cnt[k_next] != '0) begin
                            state  <= ST_DIV_X;
                            div_go <= 1'b1;
                        end else begin
                            state       <= ST_EMIT;
                            upd_empty_r <= 1'b1;
                            upd_x_r     <= '0;
                            upd_y_r     <= '0;
                        end
                    end
                end
                ST_CLEAR: begin
                    for (int i = 0; i < K; i++) begin
                        sum_x[i] <= '0;
                        sum_y[i] <= '0;
                        cnt[i]   <= '0;
                    end
                    ovf_r <= 1'b0;
                    state <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    // Output stage: strobes decode directly from the state register
    assign busy      = (state == ST_DIV_X) || (state == ST_DIV_Y) || (state == ST_EMIT);
    assign upd_valid = (state == ST_EMIT);
    assign all_done  = (state == ST_CLEAR);
    assign upd_id    = k;
    assign upd_x     = upd_x_r;
    assign upd_y     = upd_y_r;
    assign upd_empty = upd_empty_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_centroid_updater.sv
// Bench for centroid_updater: a default instance (CNT_W=16) and a second
// instance with CNT_W=2 share the same input stimulus; a per-instance
// reference model of sums/counts/means predicts every output cycle.
module tb_centroid_updater;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_cluster = 2'd0;
    logic [15:0] in_x = 16'd0;
    logic [15:0] in_y = 16'd0;
    logic        epoch_done = 1'b0;

    logic [1:0]  o_busy, o_vld, o_empty, o_ovf, o_done;
    logic [1:0]  o_id [2];
    logic [15:0] o_x  [2];
    logic [15:0] o_y  [2];

    int errors = 0;
    int checks = 0;

    // Reference model, index 0 = default instance, 1 = CNT_W=2 instance
    longint m_sx  [2][3];
    longint m_sy  [2][3];
    int     m_cnt [2][3];
    bit     m_ovf [2];
    int     cmax  [2] = '{65535, 3};

    always #5 clk = ~clk;

    centroid_updater #(.K(3), .COORD_W(16), .CNT_W(16), .SUM_W(32)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cluster(in_cluster),
        .in_x(in_x), .in_y(in_y), .epoch_done(epoch_done),
        .busy(o_busy[0]), .upd_valid(o_vld[0]), .upd_id(o_id[0]),
        .upd_x(o_x[0]), .upd_y(o_y[0]), .upd_empty(o_empty[0]),
        .ovf(o_ovf[0]), .all_done(o_done[0])
    );

    centroid_updater #(.K(3), .COORD_W(16), .CNT_W(2), .SUM_W(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cluster(in_cluster),
        .in_x(in_x), .in_y(in_y), .epoch_done(epoch_done),
        .busy(o_busy[1]), .upd_valid(o_vld[1]), .upd_id(o_id[1]),
        .upd_x(o_x[1]), .upd_y(o_y[1]), .upd_empty(o_empty[1]),
        .ovf(o_ovf[1]), .all_done(o_done[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid   = 1'b0;
        epoch_done = 1'b0;
        in_cluster = 2'd0;
        in_x       = 16'd0;
        in_y       = 16'd0;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_ovf[d] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_sx[d][c] = 0; m_sy[d][c] = 0; m_cnt[d][c] = 0;
            end
        end
    endtask

    task automatic model_add(input logic [1:0] id, input logic [15:0] x, input logic [15:0] y);
        if (id < 2'd3) begin
            for (int d = 0; d < 2; d++) begin
                if (m_cnt[d][id] == cmax[d]) begin
                    m_ovf[d] = 1'b1;
                end else begin
                    m_cnt[d][id] = m_cnt[d][id] + 1;
                    m_sx[d][id]  = m_sx[d][id] + longint'(x);
                    m_sy[d][id]  = m_sy[d][id] + longint'(y);
                end
            end
        end
    endtask

    task automatic send_point(input logic [1:0] id, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1; in_cluster = id; in_x = x; in_y = y;
        model_add(id, x, y);
        tick();
        clear_inputs();
    endtask

    // Pulse epoch_done (optionally with a point in the same cycle) and check
    // every output of both instances on every cycle until after all_done.
    // junk: 0 = idle inputs, 1 = one point at cycle 5, 2 = random traffic.
    task automatic run_epoch(input bit with_pt, input logic [1:0] pid,
                             input logic [15:0] px, input logic [15:0] py,
                             input int junk, input string tag);
        int          emit_cyc [3];
        int          c;
        int          done_cyc;
        int          ek;
        logic        exp_vld, exp_busy, exp_done, exp_empty;
        logic [15:0] ex, ey;
        epoch_done = 1'b1;
        if (with_pt) begin
            in_valid = 1'b1; in_cluster = pid; in_x = px; in_y = py;
            model_add(pid, px, py);
        end
        c = 1;
        for (int k = 0; k < 3; k++) begin
            if (m_cnt[0][k] != 0) c = c + 66;
            emit_cyc[k] = c;
            c = c + 1;
        end
        done_cyc = c;
        tick();
        clear_inputs();
        for (int cyc = 1; cyc <= done_cyc; cyc++) begin
            exp_vld = 1'b0; ek = 0;
            for (int k = 0; k < 3; k++)
                if (emit_cyc[k] == cyc) begin exp_vld = 1'b1; ek = k; end
            exp_busy = (cyc < done_cyc);
            exp_done = (cyc == done_cyc);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_vld[d] !== exp_vld) begin
                    errors++;
                    $display("FAIL %s dut%0d upd_valid cyc %0d got %b expected %b", tag, d, cyc, o_vld[d], exp_vld);
                end
                checks++;
                if (o_busy[d] !== exp_busy) begin
                    errors++;
                    $display("FAIL %s dut%0d busy cyc %0d got %b expected %b", tag, d, cyc, o_busy[d], exp_busy);
                end
                checks++;
                if (o_done[d] !== exp_done) begin
                    errors++;
                    $display("FAIL %s dut%0d all_done cyc %0d got %b expected %b", tag, d, cyc, o_done[d], exp_done);
                end
                checks++;
                if (o_ovf[d] !== m_ovf[d]) begin
                    errors++;
                    $display("FAIL %s dut%0d ovf cyc %0d got %b expected %b", tag, d, cyc, o_ovf[d], m_ovf[d]);
                end
                if (exp_vld) begin
                    exp_empty = (m_cnt[d][ek] == 0);
                    ex = exp_empty ? 16'd0 : 16'(m_sx[d][ek] / longint'(m_cnt[d][ek]));
                    ey = exp_empty ? 16'd0 : 16'(m_sy[d][ek] / longint'(m_cnt[d][ek]));
                    checks++;
                    if (o_id[d] !== 2'(ek)) begin
                        errors++;
                        $display("FAIL %s dut%0d upd_id cyc %0d got %0d expected %0d", tag, d, cyc, o_id[d], ek);
                    end
                    checks++;
                    if (o_empty[d] !== exp_empty) begin
                        errors++;
                        $display("FAIL %s dut%0d upd_empty id %0d got %b expected %b", tag, d, ek, o_empty[d], exp_empty);
                    end
                    checks++;
                    if (o_x[d] !== ex) begin
                        errors++;
                        $display("FAIL %s dut%0d upd_x id %0d got %h expected %h", tag, d, ek, o_x[d], ex);
                    end
                    checks++;
                    if (o_y[d] !== ey) begin
                        errors++;
                        $display("FAIL %s dut%0d upd_y id %0d got %h expected %h", tag, d, ek, o_y[d], ey);
                    end
                end
            end
            if (cyc < done_cyc) begin
                if (junk == 1 && cyc == 5) begin
                    in_valid = 1'b1; in_cluster = 2'd0; in_x = 16'h7fff; in_y = 16'h7fff;
                end else if (junk == 2) begin
                    in_valid   = 1'($urandom_range(0, 1));
                    in_cluster = 2'($urandom_range(0, 3));
                    in_x       = 16'($urandom);
                    in_y       = 16'($urandom);
                    epoch_done = 1'($urandom_range(0, 1));
                end
            end
            tick();
            clear_inputs();
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_busy[d], o_vld[d], o_done[d], o_ovf[d]} !== 4'b0000) begin
                errors++;
                $display("FAIL %s dut%0d after all_done busy/vld/done/ovf got %b expected 0000",
                         tag, d, {o_busy[d], o_vld[d], o_done[d], o_ovf[d]});
            end
        end
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_clear();
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_busy[d], o_vld[d], o_id[d], o_x[d], o_y[d], o_empty[d], o_ovf[d], o_done[d]} !== 38'd0) begin
                errors++;
                $display("FAIL reset dut%0d outputs got %h expected 0", d,
                         {o_busy[d], o_vld[d], o_id[d], o_x[d], o_y[d], o_empty[d], o_ovf[d], o_done[d]});
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_means();
        send_point(2'd0, 16'h0100, 16'h0100);
        send_point(2'd0, 16'h0300, 16'h0300);
        send_point(2'd1, 16'h0500, 16'h0700);
        send_point(2'd1, 16'h0700, 16'h0500);
        send_point(2'd1, 16'h0600, 16'h0600);
        run_epoch(1'b0, 2'd0, 16'd0, 16'd0, 0, "basic");
    endtask

    task automatic test_truncation();
        send_point(2'd0, 16'h0001, 16'h0001);
        send_point(2'd0, 16'h0002, 16'h0002);
        run_epoch(1'b0, 2'd0, 16'd0, 16'd0, 0, "trunc");
    endtask

    task automatic test_edge_cycles();
        send_point(2'd1, 16'h0200, 16'h0300);
        run_epoch(1'b1, 2'd1, 16'h0400, 16'h0400, 1, "edge");
        send_point(2'd0, 16'h0010, 16'h0020);
        run_epoch(1'b0, 2'd0, 16'd0, 16'd0, 0, "edge_next");
    endtask

    task automatic test_illegal_id();
        send_point(2'd3, 16'h1234, 16'h5678);
        send_point(2'd3, 16'hffff, 16'hffff);
        run_epoch(1'b0, 2'd0, 16'd0, 16'd0, 0, "illegal");
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 4; i++) send_point(2'd0, 16'h0100, 16'h0200);
        send_point(2'd2, 16'h0900, 16'h0a00);
        epoch_done = 1'b1;
        tick();
        clear_inputs();
        repeat (19) tick();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_busy[d], o_vld[d], o_id[d], o_x[d], o_y[d], o_empty[d], o_ovf[d], o_done[d]} !== 38'd0) begin
                errors++;
                $display("FAIL abort dut%0d outputs got %h expected 0", d,
                         {o_busy[d], o_vld[d], o_id[d], o_x[d], o_y[d], o_empty[d], o_ovf[d], o_done[d]});
            end
        end
        tick(); tick();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 150; i++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({o_busy[d], o_vld[d], o_done[d]} !== 3'b000) begin
                    errors++;
                    $display("FAIL abort_quiet dut%0d cyc %0d busy/vld/done got %b expected 000",
                             d, i, {o_busy[d], o_vld[d], o_done[d]});
                end
            end
            tick();
        end
        send_point(2'd2, 16'h0800, 16'h0100);
        send_point(2'd2, 16'h0a00, 16'h0300);
        run_epoch(1'b0, 2'd0, 16'd0, 16'd0, 0, "abort_fresh");
    endtask

    task automatic test_saturation();
        send_point(2'd0, 16'h0100, 16'h0400);
        send_point(2'd0, 16'h0200, 16'h0500);
        send_point(2'd0, 16'h0300, 16'h0600);
        checks++;
        if (o_ovf !== 2'b00) begin
            errors++;
            $display("FAIL sat_pre ovf got %b expected 00", o_ovf);
        end
        send_point(2'd0, 16'hf000, 16'hf000);
        checks++;
        if (o_ovf !== 2'b10) begin
            errors++;
            $display("FAIL sat_post ovf got %b expected 10", o_ovf);
        end
        run_epoch(1'b0, 2'd0, 16'd0, 16'd0, 0, "sat");
    endtask

    task automatic test_random();
        for (int e = 0; e < 3; e++) begin
            for (int i = 0; i < 30; i++)
                send_point(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            run_epoch(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      16'($urandom), 16'($urandom), 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_means();
        test_truncation();
        test_edge_cycles();
        test_illegal_id();
        test_reset_abort();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
